// File: rtl/lcd_cmd_seq.sv
// Command sequencer in front of the LCD image controller: buffers 3-bit commands in a
// FIFO and issues them one at a time, honouring busy and tracking write-back completion.
module lcd_cmd_seq #(
  parameter int DEPTH = 8,
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    in_cmd,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [2:0]    cmd,
  output logic          cmd_valid,
  input  logic          busy,
  input  logic          done,
  output logic [LW-1:0] fifo_level,
  output logic          seq_done,
  output logic          err_drop
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    WAIT_RDY,
    IDLE,
    ISSUE,
    GAP,
    DRAIN,
    FIN
  } state_t;

  state_t        state;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign in_ready = (fifo_level != LW'(DEPTH)) && (state != DRAIN) && (state != FIN);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (fifo_level != '0) && !busy;

  // NOTE: the storage array is deliberately not reset; pointers and level alone decide
  // which entries are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_RDY;
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      fifo_level <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seq_done   <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults followed by later overrides; the last assignment
      // in program order wins, so the write-back flush below beats the push/pop updates.
      cmd_valid <= 1'b0;
      if (in_valid && !in_ready) err_drop <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase

      case (state)
        WAIT_RDY: if (!busy) state <= IDLE;
        IDLE: begin
          if (pop) begin
            cmd       <= mem[rd_ptr];
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Write-back discards anything still queued behind it.
          if (cmd == 3'd0) begin
            state      <= DRAIN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
          end else begin
            state <= GAP;
          end
        end
        GAP:   state <= IDLE;
        DRAIN: begin
          if (done) begin
            state    <= FIN;
            seq_done <= 1'b1;
          end
        end
        FIN:     state <= FIN;
        default: state <= WAIT_RDY;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Scoreboard bench for lcd_cmd_seq: stimulus queues expected commands, a negedge
// monitor pops and compares on every cmd_valid strobe.
module tb_lcd_cmd_seq;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    in_cmd;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic          busy;
  logic          done;
  logic [LW-1:0] fifo_level;
  logic          seq_done;
  logic          err_drop;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         strobe_cnt = 0;
  int         strobe_cyc[$];
  logic [2:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic       busy_at_edge = 1'b0;

  lcd_cmd_seq #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_cmd     (in_cmd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .done       (done),
    .fifo_level (fifo_level),
    .seq_done   (seq_done),
    .err_drop   (err_drop)
  );

  always #5 clk = ~clk;

  // Edge counter and the busy value the DUT sampled at each rising edge.
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must be single-cycle, issued with busy low, and match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (cmd_valid) begin
          strobe_cnt++;
          strobe_cyc.push_back(cyc);
          check("strobe_single_cycle", 32'(prev_valid), 0);
          check("no_issue_while_busy", 32'(busy_at_edge), 0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got cmd %0d, expected no strobe", cmd);
          end else begin
            check("cmd_order", 32'(cmd), 32'(exp_q.pop_front()));
          end
        end
        prev_valid = cmd_valid;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one command for one edge; queue it as expected only if it should be issued.
  task automatic push(input logic [2:0] c, input bit will_issue);
    in_cmd   = c;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    if (will_issue) exp_q.push_back(c);
  endtask

  task automatic wait_strobes(input int target, input int budget, input string name);
    for (int i = 0; i < budget && strobe_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, 32'(strobe_cnt >= target), 1);
  endtask

  int base;
  int drop_cyc;
  int wb_cyc;
  logic [2:0] ov_vals [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_cmd   = 3'd0;
    busy     = 1'b1;
    done     = 1'b0;
    #12;

    // Reset values
    check("rst_cmd", 32'(cmd), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_seq_done", 32'(seq_done), 0);
    check("rst_err_drop", 32'(err_drop), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    tick(1);
    reset = 1'b0;

    // Startup hold: busy high for 70 cycles with 4,2,5 queued
    push(3'd4, 1'b1);
    push(3'd2, 1'b1);
    push(3'd5, 1'b1);
    check("startup_level", 32'(fifo_level), 3);
    tick(67);
    check("startup_no_strobe", 32'(strobe_cnt), 0);
    base     = strobe_cnt;
    busy     = 1'b0;
    drop_cyc = cyc;
    wait_strobes(base + 3, 40, "startup_strobes");
    if (strobe_cnt >= base + 3) begin
      check("startup_latency", 32'(strobe_cyc[base] - drop_cyc), 2);
      check("startup_gap_1", 32'(strobe_cyc[base + 1] - strobe_cyc[base]), 3);
      check("startup_gap_2", 32'(strobe_cyc[base + 2] - strobe_cyc[base + 1]), 3);
    end
    check("startup_level_end", 32'(fifo_level), 0);
    tick(1);

    // Full / overflow with busy held
    ov_vals = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    busy = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) push(ov_vals[i], 1'b1);
    check("full_level", 32'(fifo_level), 8);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_err_before", 32'(err_drop), 0);
    push(3'd3, 1'b0);
    check("overflow_err_drop", 32'(err_drop), 1);
    check("overflow_level", 32'(fifo_level), 8);
    base = strobe_cnt;
    busy = 1'b0;
    wait_strobes(base + 8, 60, "overflow_strobes");
    tick(6);
    check("overflow_issue_count", 32'(strobe_cnt - base), 8);
    check("overflow_level_end", 32'(fifo_level), 0);

    // Busy raised right after the first strobe
    busy = 1'b1;
    push(3'd1, 1'b1);
    push(3'd3, 1'b1);
    push(3'd6, 1'b1);
    base = strobe_cnt;
    busy = 1'b0;
    wait_strobes(base + 1, 10, "midbusy_first");
    busy = 1'b1;
    tick(10);
    check("midbusy_held", 32'(strobe_cnt - base), 1);
    busy     = 1'b0;
    drop_cyc = cyc;
    wait_strobes(base + 3, 30, "midbusy_rest");
    if (strobe_cnt >= base + 3)
      check("midbusy_resume_after_drop", 32'(strobe_cyc[base + 1] > drop_cyc), 1);
    tick(1);

    // Write-back: 7,0 issued, 4 flushed, done 65 cycles after the 0 strobe
    busy = 1'b1;
    push(3'd7, 1'b1);
    push(3'd0, 1'b1);
    push(3'd4, 1'b0);
    base = strobe_cnt;
    busy = 1'b0;
    wait_strobes(base + 2, 20, "wb_strobes");
    tick(1);
    check("wb_flush_level", 32'(fifo_level), 0);
    check("wb_drain_in_ready", 32'(in_ready), 0);
    check("wb_drain_seq_done", 32'(seq_done), 0);
    tick(63);
    done = 1'b1;
    @(negedge clk);
    check("wb_seq_done_before", 32'(seq_done), 0);
    tick(1);
    done = 1'b0;
    check("wb_seq_done_after", 32'(seq_done), 1);
    check("wb_fin_in_ready", 32'(in_ready), 0);
    check("wb_cmd_stable", 32'(cmd), 0);
    tick(5);
    check("wb_no_more_issues", 32'(strobe_cnt - base), 2);

    // Async reset in the middle of DRAIN
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    busy  = 1'b0;
    base  = strobe_cnt;
    push(3'd0, 1'b1);
    wait_strobes(base + 1, 10, "drain2_strobe");
    tick(1);
    check("drain2_err_cleared", 32'(err_drop), 0);
    check("drain2_in_ready", 32'(in_ready), 0);
    push(3'd5, 1'b0);
    check("drain2_err_set", 32'(err_drop), 1);
    @(negedge clk);
    #2;
    busy  = 1'b1;
    reset = 1'b1;
    #1;
    check("async_cmd", 32'(cmd), 0);
    check("async_cmd_valid", 32'(cmd_valid), 0);
    check("async_level", 32'(fifo_level), 0);
    check("async_seq_done", 32'(seq_done), 0);
    check("async_err_drop", 32'(err_drop), 0);
    check("async_in_ready", 32'(in_ready), 1);
    tick(1);
    reset = 1'b0;

    // Back in WAIT_RDY: a queued command waits for busy low, then one extra cycle
    base = strobe_cnt;
    push(3'd6, 1'b1);
    tick(3);
    check("post_reset_hold", 32'(strobe_cnt - base), 0);
    busy     = 1'b0;
    drop_cyc = cyc;
    wait_strobes(base + 1, 10, "post_reset_strobe");
    if (strobe_cnt >= base + 1)
      check("post_reset_wait_rdy_latency", 32'(strobe_cyc[base] - drop_cyc), 2);
    tick(4);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
